net_test_sequencer: RTL and testbench

Self-test sequencer that sits directly upstream of the `net` classifier instance and drives its `rst_n`/`start`/`x` inputs. It consumes the net's `y`/`done` outputs. On one `go` pulse it walks every binary input pattern, for I=2 that is 00, 01, 10 and 11. For each pattern it:
- encodes the pattern as IEEE-754 single-precision words,
- resets and starts the net,
- waits for `done`,
- thresholds `y` at 0.5 and scores the result against the parity (XOR) of the pattern.

The results drive board LEDs in place of a manual switch/button flow.

---
 rtl/net_test_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_net_test_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/net_test_sequencer.sv
// net_test_sequencer: self-test driver for the `net` classifier.
// On a `go` pulse it sweeps every binary input pattern, encodes it as IEEE-754
// singles, resets and starts the net, waits for `done`, and thresholds `y` at
// 0.5. It then scores `y` against the XOR parity of the pattern.
// Optional build macro: SEQ_TIMEOUT_EN adds a per-pattern WAIT watchdog of TIMEOUT cycles.
module net_test_sequencer #(
   parameter int I       = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go,
   output logic              net_rst_n,
   output logic              net_start,
   output logic [32*I-1:0]   net_x,
   input  logic [31:0]       net_y,
   input  logic              net_done,
   output logic              busy,
   output logic              finished,
   output logic [I:0]        pass_cnt,
   output logic [2**I-1:0]   fail_mask,
   output logic              timeout_err
);

   localparam logic [31:0] FP_ONE      = 32'h3f800000;
   localparam logic [30:0] FP_HALF_MAG = 31'h3f000000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_NRST,
      S_START,
      S_WAIT,
      S_FIN,
      S_DONE
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [I-1:0]      p_reg;
   logic [32*I-1:0]   x_enc;
   logic              go_accept;
   logic              score;
   logic              predicted;
   logic              expected;
   logic              wait_timeout;
   logic              wait_exit;

   // Word k carries bit k of the pattern; word 0 sits in the most significant slot.
   for (genvar gi = 0; gi < I; gi++) begin : g_enc
      assign x_enc[32*(I-1-gi) +: 32] = p_reg[gi] ? FP_ONE : 32'h00000000;
   end

   // go is only honoured when no sweep is running.
   assign go_accept = go && ((state_reg == S_IDLE) || (state_reg == S_DONE));

   // Strictly greater than +0.5: sign clear and magnitude above 0.5's bit pattern.
   assign predicted = ~net_y[31] & (net_y[30:0] > FP_HALF_MAG);
   assign expected  = ^p_reg;
   assign score     = (state_reg == S_WAIT) && net_done;
   assign wait_exit = score || wait_timeout;

`ifdef SEQ_TIMEOUT_EN
   localparam int          CW          = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_CNT = TIMEOUT[CW-1:0];

   logic [CW-1:0] wcnt_reg;
   logic          timeout_err_reg;

   // done has priority, so a late done on the final count is still scored.
   assign wait_timeout = (state_reg == S_WAIT) && !net_done && (wcnt_reg == TIMEOUT_CNT);
   assign timeout_err  = timeout_err_reg;

   // Wait counter: cleared in START, counts WAIT cycles up to the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_reg <= '0;
      end else if (state_reg == S_START) begin
         wcnt_reg <= '0;
      end else if ((state_reg == S_WAIT) && !net_done && (wcnt_reg != TIMEOUT_CNT)) begin
         wcnt_reg <= wcnt_reg + 1'b1;
      end
   end

   // Sticky timeout flag, cleared when a new sweep is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_err_reg <= 1'b0;
      end else if (go_accept) begin
         timeout_err_reg <= 1'b0;
      end else if (wait_timeout) begin
         timeout_err_reg <= 1'b1;
      end
   end
`else
   // No watchdog: WAIT lasts until done. The AND keeps TIMEOUT referenced in this build.
   assign wait_timeout = 1'b0;
   assign timeout_err  = 1'b0 & (TIMEOUT != 0);
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic for the sweep.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_DONE: if (go) state_next = S_LOAD;
         S_LOAD:         state_next = S_NRST;
         S_NRST:         state_next = S_START;
         S_START:        state_next = S_WAIT;
         S_WAIT: begin
            if (wait_exit) begin
               state_next = (&p_reg) ? S_FIN : S_LOAD;
            end
         end
         S_FIN:          state_next = S_DONE;
         default:        state_next = S_IDLE;
      endcase
   end

   // Registered outputs, pattern index and scoreboard.
   // The net strobes follow state_next so that they are valid during NRST and START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         net_rst_n <= 1'b1;
         net_start <= 1'b0;
         net_x     <= '0;
         busy      <= 1'b0;
         finished  <= 1'b0;
         pass_cnt  <= '0;
         fail_mask <= '0;
         p_reg     <= '0;
      end else begin
         net_rst_n <= (state_next != S_NRST);
         net_start <= (state_next == S_START);
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (go) begin
                  pass_cnt  <= '0;
                  fail_mask <= '0;
                  finished  <= 1'b0;
                  busy      <= 1'b1;
                  p_reg     <= '0;
               end
            end
            S_LOAD: begin
               net_x <= x_enc;
            end
            S_WAIT: begin
               if (score) begin
                  if (predicted == expected) begin
                     pass_cnt <= pass_cnt + 1'b1;
                  end else begin
                     fail_mask[p_reg] <= 1'b1;
                  end
               end else if (wait_timeout) begin
                  fail_mask[p_reg] <= 1'b1;
               end
               if (wait_exit && !(&p_reg)) begin
                  p_reg <= p_reg + 1'b1;
               end
            end
            S_FIN: begin
               busy     <= 1'b0;
               finished <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_net_test_sequencer.sv
// Testbench for net_test_sequencer: a behavioural net model with per-pattern
// output value and done latency, plus a reference that derives the expected
// score, mask and sweep length from real-valued arithmetic.
module tb_net_test_sequencer;

   localparam int I    = 2;
   localparam int NPAT = 4;
`ifdef SEQ_TIMEOUT_EN
   localparam int TB_TIMEOUT = 15;
`else
   localparam int TB_TIMEOUT = 1023;
`endif
   localparam int BUDGET = 600;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            go = 1'b0;
   logic            net_rst_n;
   logic            net_start;
   logic [32*I-1:0] net_x;
   logic [31:0]     net_y;
   logic            net_done;
   logic            busy;
   logic            finished;
   logic [I:0]      pass_cnt;
   logic [NPAT-1:0] fail_mask;
   logic            timeout_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   net_test_sequencer #(.I(I), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .go         (go),
      .net_rst_n  (net_rst_n),
      .net_start  (net_start),
      .net_x      (net_x),
      .net_y      (net_y),
      .net_done   (net_done),
      .busy       (busy),
      .finished   (finished),
      .pass_cnt   (pass_cnt),
      .fail_mask  (fail_mask),
      .timeout_err(timeout_err)
   );

   // ---------------- net model ----------------
   logic [31:0]     y_tab [NPAT];
   int              lat_tab [NPAT];
   bit              never_done = 1'b0;
   logic [32*I-1:0] x_log [$];
   logic            m_run = 1'b0;
   logic            m_done = 1'b0;
   int              m_cnt = 0;
   int              m_pat = 0;

   function automatic int decode_x(input logic [32*I-1:0] x);
      int p = 0;
      for (int k = 0; k < I; k++) begin
         if (x[32*(I-1-k) +: 32] == 32'h3f800000) p = p | (1 << k);
      end
      return p;
   endfunction

   // done rises lat-1 edges after start is sampled, so it is seen on the lat-th WAIT cycle
   always @(posedge clk) begin
      if (!net_rst_n) begin
         m_run  <= 1'b0;
         m_done <= 1'b0;
         m_cnt  <= 0;
      end else if (net_start) begin
         m_run  <= 1'b1;
         m_done <= 1'b0;
         m_cnt  <= 1;
         m_pat  <= decode_x(net_x);
         x_log.push_back(net_x);
      end else if (m_run && !m_done && !never_done) begin
         if (m_cnt >= lat_tab[m_pat] - 1) m_done <= 1'b1;
         else m_cnt <= m_cnt + 1;
      end
   end

   assign net_done = m_done;
   assign net_y    = m_done ? y_tab[m_pat] : 32'h00000000;

   // ---------------- reference ----------------
   function automatic real fp_to_real(input logic [31:0] b);
      int  e = int'(b[30:23]);
      real m = real'(b[22:0]);
      real v;
      if (e == 0) v = m * (2.0 ** (-149));
      else        v = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
      return b[31] ? -v : v;
   endfunction

   function automatic logic [32*I-1:0] ref_x(input int p);
      logic [32*I-1:0] v = '0;
      for (int k = 0; k < I; k++) begin
         if (((p >> k) & 1) == 1) v[32*(I-1-k) +: 32] = 32'h3f800000;
      end
      return v;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_net_rst_n"}, net_rst_n, 1);
      check_eq({pfx, "_net_start"}, net_start, 0);
      check_eq({pfx, "_net_x"}, net_x, 0);
      check_eq({pfx, "_busy"}, busy, 0);
      check_eq({pfx, "_finished"}, finished, 0);
      check_eq({pfx, "_pass_cnt"}, pass_cnt, 0);
      check_eq({pfx, "_fail_mask"}, fail_mask, 0);
      check_eq({pfx, "_timeout_err"}, timeout_err, 0);
   endtask

   // mode 0: plain sweep; 1: extra go during WAIT of pattern 1; 2: reset during WAIT of pattern 2
   task automatic run_sweep(input int mode, output int cycles, output bit aborted);
      bit injected = 1'b0;
      x_log.delete();
      aborted = 1'b0;
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      check_eq("go_busy", busy, 1);
      check_eq("go_clear_finished", finished, 0);
      check_eq("go_clear_pass", pass_cnt, 0);
      check_eq("go_clear_mask", fail_mask, 0);
      cycles = 0;
      while (!finished && cycles < BUDGET) begin
         @(posedge clk); #1;
         cycles++;
         go = 1'b0;
         if (mode == 1 && !injected && x_log.size() == 2 && !net_start && !net_done) begin
            go = 1'b1;
            injected = 1'b1;
         end
         if (mode == 2 && x_log.size() == 3 && !net_start && !net_done) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("async_rst");
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            aborted = 1'b1;
            break;
         end
      end
      if (!aborted) check_eq("sweep_finished", finished, 1);
   endtask

   task automatic check_sweep(input string tag, input int cycles, input bit to_mode);
      int exp_pass = 0;
      int exp_mask = 0;
      int exp_cyc  = 1;
      for (int p = 0; p < NPAT; p++) begin
         bit pred = fp_to_real(y_tab[p]) > 0.5;
         bit par  = ($countones(p) % 2) == 1;
         if (to_mode) begin
            exp_mask = exp_mask | (1 << p);
            exp_cyc  = exp_cyc + 3 + TB_TIMEOUT + 1;
         end else begin
            if (pred == par) exp_pass++;
            else exp_mask = exp_mask | (1 << p);
            exp_cyc = exp_cyc + 3 + lat_tab[p];
         end
      end
      $display("sweep %s: cycles=%0d pass_cnt=%0d fail_mask=%b timeout_err=%0d", tag, cycles, pass_cnt, fail_mask, timeout_err);
      check_eq({tag, "_pass_cnt"}, pass_cnt, exp_pass);
      check_eq({tag, "_fail_mask"}, fail_mask, exp_mask);
      check_eq({tag, "_cycles"}, cycles, exp_cyc);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_timeout_err"}, timeout_err, to_mode);
      check_eq({tag, "_npat"}, x_log.size(), NPAT);
      for (int p = 0; p < NPAT && p < x_log.size(); p++) begin
         check_eq({tag, "_net_x"}, x_log[p], ref_x(p));
      end
   endtask

   task automatic set_table(input logic [31:0] y0, input logic [31:0] y1,
                            input logic [31:0] y2, input logic [31:0] y3, input int lat);
      y_tab[0] = y0; y_tab[1] = y1; y_tab[2] = y2; y_tab[3] = y3;
      for (int p = 0; p < NPAT; p++) lat_tab[p] = lat;
   endtask

   function automatic logic [31:0] rand_y();
      case ($urandom_range(0, 6))
         0: return 32'h00000000;
         1: return 32'h3f800000;
         2: return 32'h3f000000;
         3: return 32'h3f000001;
         4: return 32'hbf800000;
         5: return 32'h80000000;
         default: begin
            logic [31:0] r = $urandom;
            r[30:23] = 8'($urandom_range(0, 254));
            return r;
         end
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_watchdog: got no end, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      bit  ab;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      set_table(32'h0, 32'h3f800000, 32'h3f800000, 32'h0, 5);
      run_sweep(0, cyc, ab);
      check_sweep("xor_lat5", cyc, 1'b0);
      check_eq("xor_lat5_exact_33", cyc, 33);

      set_table(32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f800000, 3);
      run_sweep(0, cyc, ab);
      check_sweep("all_one", cyc, 1'b0);

      set_table(32'h3f000000, 32'h3f000000, 32'h3f000000, 32'h3f000000, 2);
      run_sweep(0, cyc, ab);
      check_sweep("half", cyc, 1'b0);

      set_table(32'hbf800000, 32'hbf800000, 32'hbf800000, 32'hbf800000, 4);
      run_sweep(0, cyc, ab);
      check_sweep("neg_one", cyc, 1'b0);

      set_table(32'h0, 32'h3f800000, 32'h3f800000, 32'h0, 6);
      run_sweep(1, cyc, ab);
      check_sweep("go_ignored", cyc, 1'b0);

      set_table(32'h3f800000, 32'h0, 32'h3f800000, 32'h0, 5);
      run_sweep(2, cyc, ab);
      check_eq("reset_aborted", ab, 1);
      @(posedge clk); #1;
      check_reset_outputs("post_reset");
      run_sweep(0, cyc, ab);
      check_sweep("after_reset", cyc, 1'b0);

      for (int t = 0; t < 20; t++) begin
         for (int p = 0; p < NPAT; p++) begin
            y_tab[p]   = rand_y();
            lat_tab[p] = $urandom_range(2, 8);
         end
         run_sweep(0, cyc, ab);
         check_sweep($sformatf("rand%0d", t), cyc, 1'b0);
      end

`ifdef SEQ_TIMEOUT_EN
      never_done = 1'b1;
      run_sweep(0, cyc, ab);
      check_sweep("timeout", cyc, 1'b1);
      never_done = 1'b0;
      set_table(32'h0, 32'h3f800000, 32'h3f800000, 32'h0, TB_TIMEOUT + 1);
      run_sweep(0, cyc, ab);
      check_sweep("done_at_limit", cyc, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
